// File: rtl/mbgd_apb_master.sv
// rtl/mbgd_apb_master.sv - APB master fed by a command FIFO, optional timeout via APB_MST_TIMEOUT_EN
module mbgd_apb_master #(
    parameter int ADDR       = 8,
    parameter int DATA       = 8,
    parameter int FIFO_DEPTH = 4,
    parameter int TIMEOUT    = 16
) (
    input  logic            apb_pclk,
    input  logic            resetn,
    input  logic            cmd_valid,
    output logic            cmd_ready,
    input  logic            cmd_write,
    input  logic [ADDR-1:0] cmd_addr,
    input  logic [DATA-1:0] cmd_wdata,
    output logic            rsp_valid,
    output logic [DATA-1:0] rsp_rdata,
    output logic            rsp_err,
    output logic            apb_psel,
    output logic            apb_penable,
    output logic            apb_pwrite,
    output logic [ADDR-1:0] apb_paddress,
    output logic [DATA-1:0] apb_pwdata,
    input  logic            apb_pready,
    input  logic [DATA-1:0] apb_prdata,
    output logic            busy,
    output logic [1:0]      state
);

    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int EW = 1 + ADDR + DATA;

    typedef enum logic [1:0] {
        IDLE   = 2'b00,
        SETUP  = 2'b01,
        ACCESS = 2'b10
    } state_t;

    state_t          st;
    logic [EW-1:0]   mem [FIFO_DEPTH];
    logic [PW-1:0]   rd_ptr;
    logic [PW-1:0]   wr_ptr;
    logic [PW:0]     count;
    logic [PW:0]     count_nxt;
    logic            full;
    logic            push;
    logic            pop;
    logic            done;
    logic            tmo_hit;
    logic            xfer_active;
    logic [EW-1:0]   head;
    logic            head_write;
    logic [ADDR-1:0] head_addr;
    logic [DATA-1:0] head_wdata;

    // Full is judged on the registered count only, so a pop cannot make room for a same-cycle push
    assign full      = (count == (PW+1)'(FIFO_DEPTH));
    assign cmd_ready = !full;
    assign push      = cmd_valid && !full;
    assign done      = (st == ACCESS) && (apb_pready || tmo_hit);
    assign pop       = done;
    assign count_nxt = count + {{PW{1'b0}}, push} - {{PW{1'b0}}, pop};

    assign head       = mem[rd_ptr];
    assign head_write = head[EW-1];
    assign head_addr  = head[EW-2 -: ADDR];
    assign head_wdata = head[DATA-1:0];

    // The head entry stays put until its transfer completes, so address/data are stable over SETUP and ACCESS
    assign xfer_active  = (st == SETUP) || (st == ACCESS);
    assign apb_pwrite   = xfer_active && head_write;
    assign apb_paddress = xfer_active ? head_addr : '0;
    assign apb_pwdata   = (xfer_active && head_write) ? head_wdata : '0;
    assign busy         = (count != '0) || (st != IDLE);
    assign state        = st;

`ifdef APB_MST_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT + 1);
    logic [TW-1:0] tmo_cnt;

    // The TIMEOUT-th consecutive stalled ACCESS cycle is itself the aborting completion
    assign tmo_hit = (st == ACCESS) && !apb_pready && (tmo_cnt == TW'(TIMEOUT - 1));

    // Count consecutive stalled ACCESS cycles; each new transfer starts from zero
    always_ff @(posedge apb_pclk or negedge resetn) begin
        if (!resetn) begin
            tmo_cnt <= '0;
        end else if (st == SETUP) begin
            tmo_cnt <= '0;
        end else if ((st == ACCESS) && !apb_pready) begin
            tmo_cnt <= tmo_cnt + 1'b1;
        end
    end
`else
    // Without the counter ACCESS waits for the slave forever; TIMEOUT is a don't-care here
    assign tmo_hit = (TIMEOUT < 0);
`endif

    // Command storage; contents need no reset since reads are masked by the pointers/state
    always_ff @(posedge apb_pclk) begin
        if (push) begin
            mem[wr_ptr] <= {cmd_write, cmd_addr, cmd_wdata};
        end
    end

    // FIFO pointers and occupancy
    always_ff @(posedge apb_pclk or negedge resetn) begin
        if (!resetn) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            count <= count_nxt;
        end
    end

    // APB phase sequencing with registered select/enable and response capture
    always_ff @(posedge apb_pclk or negedge resetn) begin
        if (!resetn) begin
            st          <= IDLE;
            apb_psel    <= 1'b0;
            apb_penable <= 1'b0;
            rsp_valid   <= 1'b0;
            rsp_rdata   <= '0;
            rsp_err     <= 1'b0;
        end else begin
            rsp_valid <= 1'b0;
            case (st)
                IDLE: begin
                    if (count != '0) begin
                        st          <= SETUP;
                        apb_psel    <= 1'b1;
                        apb_penable <= 1'b0;
                    end
                end
                SETUP: begin
                    st          <= ACCESS;
                    apb_psel    <= 1'b1;
                    apb_penable <= 1'b1;
                end
                ACCESS: begin
                    if (done) begin
                        rsp_valid <= 1'b1;
                        rsp_err   <= tmo_hit;
                        rsp_rdata <= (head_write || tmo_hit) ? '0 : apb_prdata;
                        if (count_nxt != '0) begin
                            st          <= SETUP;
                            apb_psel    <= 1'b1;
                            apb_penable <= 1'b0;
                        end else begin
                            st          <= IDLE;
                            apb_psel    <= 1'b0;
                            apb_penable <= 1'b0;
                        end
                    end
                end
                default: begin
                    st          <= IDLE;
                    apb_psel    <= 1'b0;
                    apb_penable <= 1'b0;
                end
            endcase
        end
    end

endmodule
